// File: rtl/mips_pkg.sv
// Shared encodings and constants for the 16-bit MIPS pipeline.
package mips_pkg;

  localparam int MIPS_DATA_W = 16;
  localparam int MIPS_REG_AW = 3;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_SLT   = 2'b11;

  localparam logic [2:0] F_ADD = 3'b000;
  localparam logic [2:0] F_SUB = 3'b001;
  localparam logic [2:0] F_AND = 3'b010;
  localparam logic [2:0] F_OR  = 3'b011;
  localparam logic [2:0] F_SLT = 3'b100;
  localparam logic [2:0] F_MUL = 3'b101;
  localparam logic [2:0] F_SLL = 3'b110;
  localparam logic [2:0] F_SRL = 3'b111;

  typedef enum logic {EX_IDLE, EX_MUL} ex_state_e;

endpackage

// File: rtl/execute_stage_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, low DATA_W bits kept.
module mul_iter #(
  parameter int DATA_W = 16,
  parameter int CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] multiplicand,
  input  logic [DATA_W-1:0] multiplier,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_next;
  logic [CW-1:0]     count;

  // product is the accumulator after the current step, so the final step lands on the done edge
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign product  = acc_next;
  assign done     = busy && (count == CW'(CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      busy   <= 1'b0;
    end else if (abort) begin
      acc   <= '0;
      count <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      mcand  <= multiplicand;
      mplier <= multiplier;
      acc    <= '0;
      count  <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// EX stage: operand select, ALU, branch target/compare, iterative mul and the EX/MEM register.
module execute_stage
  import mips_pkg::*;
#(
  parameter int DATA_W     = MIPS_DATA_W,
  parameter int REG_AW     = MIPS_REG_AW,
  parameter int MUL_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic              flush,
  input  logic [DATA_W-1:0] read_data_1,
  input  logic [DATA_W-1:0] read_data_2,
  input  logic [DATA_W-1:0] immediate,
  input  logic [DATA_W-1:0] pc_plus_two,
  input  logic [REG_AW-1:0] rt_addr,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic [2:0]        funct,
  input  logic              RegDst,
  input  logic              ALUSrc,
  input  logic              MemtoReg,
  input  logic              RegWrite,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              Branch,
  input  logic [1:0]        ALUOp,
  output logic              stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] store_data,
  output logic [REG_AW-1:0] write_register,
  output logic [DATA_W-1:0] branch_target,
  output logic              branch_taken,
  output logic              MemtoReg_o,
  output logic              RegWrite_o,
  output logic              MemRead_o,
  output logic              MemWrite_o
);

  ex_state_e state;

  logic [DATA_W-1:0] op_a, op_b, sum, diff, slt_word, alu_out, target;
  logic [REG_AW-1:0] wr_sel, wr_q;
  logic              is_mul, accept, taken;
  logic              mul_busy, mul_done, mul_finish;
  logic [DATA_W-1:0] mul_product;

  // bundle captured at multiply accept, replayed into EX/MEM when the product is ready
  logic [DATA_W-1:0] p_store, p_target;
  logic [REG_AW-1:0] p_wr;
  logic              p_taken, p_m2r, p_rw, p_mr, p_mw;

  assign op_a     = read_data_1;
  assign op_b     = ALUSrc ? immediate : read_data_2;
  assign sum      = op_a + op_b;
  assign diff     = op_a - op_b;
  assign slt_word = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
  assign target   = pc_plus_two + (immediate << 1);
  assign taken    = Branch & (diff == '0);
  assign wr_sel   = RegDst ? rd_addr : rt_addr;

  assign stall      = (state == EX_MUL);
  assign is_mul     = (ALUOp == ALU_RTYPE) && (funct == F_MUL);
  assign accept     = id_valid & ~stall & ~flush;
  assign mul_finish = (state == EX_MUL) && mul_busy && mul_done;

  assign write_register = ex_valid ? wr_q : '0;

  always_comb begin
    alu_out = sum;
    case (ALUOp)
      ALU_ADD: alu_out = sum;
      ALU_SUB: alu_out = diff;
      ALU_SLT: alu_out = slt_word;
      ALU_RTYPE: begin
        case (funct)
          F_ADD:   alu_out = sum;
          F_SUB:   alu_out = diff;
          F_AND:   alu_out = op_a & op_b;
          F_OR:    alu_out = op_a | op_b;
          F_SLT:   alu_out = slt_word;
          F_SLL:   alu_out = op_a << op_b[3:0];
          F_SRL:   alu_out = op_a >> op_b[3:0];
          default: alu_out = '0;
        endcase
      end
    endcase
  end

  mul_iter #(
    .DATA_W (DATA_W),
    .CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (accept & is_mul),
    .abort        (flush),
    .multiplicand (op_a),
    .multiplier   (op_b),
    .busy         (mul_busy),
    .done         (mul_done),
    .product      (mul_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_store  <= '0;
      p_target <= '0;
      p_wr     <= '0;
      p_taken  <= 1'b0;
      p_m2r    <= 1'b0;
      p_rw     <= 1'b0;
      p_mr     <= 1'b0;
      p_mw     <= 1'b0;
    end else if (accept && is_mul) begin
      p_store  <= read_data_2;
      p_target <= target;
      p_wr     <= wr_sel;
      p_taken  <= taken;
      p_m2r    <= MemtoReg;
      p_rw     <= RegWrite;
      p_mr     <= MemRead;
      p_mw     <= MemWrite;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= EX_IDLE;
      ex_valid      <= 1'b0;
      alu_result    <= '0;
      store_data    <= '0;
      wr_q          <= '0;
      branch_target <= '0;
      branch_taken  <= 1'b0;
      MemtoReg_o    <= 1'b0;
      RegWrite_o    <= 1'b0;
      MemRead_o     <= 1'b0;
      MemWrite_o    <= 1'b0;
    end else if (flush) begin
      state      <= EX_IDLE;
      ex_valid   <= 1'b0;
      RegWrite_o <= 1'b0;
      MemRead_o  <= 1'b0;
      MemWrite_o <= 1'b0;
    end else if (state == EX_MUL) begin
      if (mul_finish) begin
        state         <= EX_IDLE;
        ex_valid      <= 1'b1;
        alu_result    <= mul_product;
        store_data    <= p_store;
        wr_q          <= p_wr;
        branch_target <= p_target;
        branch_taken  <= p_taken;
        MemtoReg_o    <= p_m2r;
        RegWrite_o    <= p_rw;
        MemRead_o     <= p_mr;
        MemWrite_o    <= p_mw;
      end
    end else if (accept) begin
      if (is_mul) begin
        state    <= EX_MUL;
        ex_valid <= 1'b0;
      end else begin
        ex_valid      <= 1'b1;
        alu_result    <= alu_out;
        store_data    <= read_data_2;
        wr_q          <= wr_sel;
        branch_target <= target;
        branch_taken  <= taken;
        MemtoReg_o    <= MemtoReg;
        RegWrite_o    <= RegWrite;
        MemRead_o     <= MemRead;
        MemWrite_o    <= MemWrite;
      end
    end else begin
      ex_valid <= 1'b0;
    end
  end

endmodule
